voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
Allocates note events from the song sequencer onto the three note-player voices. Replaces fixed round-robin dispatch with occupancy-aware allocation:
- Tracks the remaining duration of every voice in beats.
- Picks an idle voice, or steals the voice closest to finishing.
- Buffers bursts of note events in a small request FIFO with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, request FIFO entries; power of 2, minimum 2
NOTE_W, 6, note code width
DUR_W, 6, duration width in beats

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous clear of FIFO and all voice counters
play  in  1  1 = run, 0 = pause
beat  in  1  one-cycle beat strobe
fast_mode  in  1  counters decrement by 2 per beat instead of 1
note_valid  in  1  request present
note_in  in  NOTE_W  requested note
dur_in  in  DUR_W  requested duration in beats
note_ready  out  1  FIFO can accept; equals !full
note0/duration0/load_note0  out  NOTE_W/DUR_W/1  voice 0 load
note1/duration1/load_note1  out  NOTE_W/DUR_W/1  voice 1 load
note2/duration2/load_note2  out  NOTE_W/DUR_W/1  voice 2 load
voice_busy  out  3  bit i = 1 when remaining[i] != 0
steal  out  1  one-cycle pulse; the current load preempted a busy voice
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
Reset (reset=0, asynchronous):
- FIFO empty; all remaining[i] = 0.
- All note/duration/load outputs, steal, voice_busy and fifo_count = 0.
- note_ready = 1 as soon as reset is released.
- Reset asserted mid-operation aborts everything immediately; there is no pending load afterwards.

Request FIFO:
- Write when note_valid && note_ready.
- Read (dispatch) when non-empty && play && !flush.
- Simultaneous read and write while full: write is refused, because note_ready = 0 is computed from the registered full flag.
- Simultaneous read and write while empty: the write lands; no dispatch that cycle.
- Pointers wrap modulo FIFO_DEPTH.

Dispatch:
- At most one entry per cycle, from the FIFO head.
- Outputs are registered. Earliest timing: request accepted at edge k, load_noteN is high for exactly the cycle after edge k+1 (two-edge latency).
- noteN and durationN hold the loaded values during the pulse and are 0 otherwise.
- Entry with dur_in == 0: popped and discarded. No load, no steal, no counter change.

Voice selection, evaluated on registered remaining[] before any same-cycle beat:
1. Lowest-index voice with remaining == 0.
2. If none is idle: the voice with the smallest remaining value, lowest index on ties. Assert steal together with the load pulse.

Counters, per voice:
- On a dispatch, the selected voice loads remaining = duration. No decrement is applied to that voice that cycle, even if beat = 1.
- Otherwise, on play && beat: remaining = remaining - dec, where dec = 2 if fast_mode else 1, saturating at 0.
- play = 0: counters freeze, dispatch halts, FIFO still accepts writes.

flush (priority below reset, above everything else):
- Next edge: FIFO empty, all remaining = 0, no load, no steal.
- A write presented in the same cycle as flush is dropped.

Controller FSM, states RUN, PAUSE, FLUSH:
- RUN → PAUSE when play = 0.
- PAUSE → RUN when play = 1.
- Any state → FLUSH when flush = 1.
- FLUSH → RUN (play = 1) or PAUSE (play = 0) one cycle later.
- FLUSH lasts exactly one cycle. No dispatch and no counting occur in FLUSH, and note_ready = 0 during it.

Test Plan:
- Single request, play=1: note_in=10, dur_in=4, valid at edge k → load_note0=1, note0=10, duration0=4 in the cycle after edge k+1; voice_busy=001. After 4 beats, voice_busy=000.
- Three back-to-back requests (durations 8, 6, 5), then a fourth (note 20, dur 3) with no beats in between → voices 0, 1, 2 loaded on consecutive cycles. The fourth steals voice 2 (smallest remaining, 5): steal=1, load_note2=1, note2=20.
- FIFO_DEPTH=4 with play=0: five consecutive valid requests → four accepted, note_ready=0 on the fifth, fifo_count=4, no loads. Setting play=1 drains one entry per cycle.
- fast_mode=1, voice loaded with dur=3 → remaining goes 3 → 1 → 0 on successive beats. No underflow; busy bit clears after the second beat.
- Beat coincident with dispatch into voice 0 (dur 5) while voice 1 has remaining 2 → voice 0 remaining=5, voice 1 remaining=1.
- flush with 3 entries queued and all voices busy → next cycle fifo_count=0, voice_busy=000, no load pulses. Asserting reset=0 mid-dispatch clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - occupancy-aware note allocator for three note-player voices
module voice_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          play,
  input  logic                          beat,
  input  logic                          fast_mode,
  input  logic                          note_valid,
  input  logic [NOTE_W-1:0]             note_in,
  input  logic [DUR_W-1:0]              dur_in,
  output logic                          note_ready,
  output logic [NOTE_W-1:0]             note0,
  output logic [DUR_W-1:0]              duration0,
  output logic                          load_note0,
  output logic [NOTE_W-1:0]             note1,
  output logic [DUR_W-1:0]              duration1,
  output logic                          load_note1,
  output logic [NOTE_W-1:0]             note2,
  output logic [DUR_W-1:0]              duration2,
  output logic                          load_note2,
  output logic [2:0]                    voice_busy,
  output logic                          steal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_FLUSH} state_e;

  state_e state_q, state_d;

  logic [NOTE_W-1:0] fifo_note_q [FIFO_DEPTH];
  logic [DUR_W-1:0]  fifo_dur_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DUR_W-1:0]  remaining_q [3];
  logic [DUR_W-1:0]  remaining_d [3];

  logic [NOTE_W-1:0] note_q [3];
  logic [NOTE_W-1:0] note_d [3];
  logic [DUR_W-1:0]  dur_q  [3];
  logic [DUR_W-1:0]  dur_d  [3];
  logic [2:0]        load_q, load_d;
  logic              steal_q, steal_d;

  logic              full, empty, in_flush;
  logic              wr_en, rd_en, load_en, count_en;
  logic [NOTE_W-1:0] head_note;
  logic [DUR_W-1:0]  head_dur;
  logic [DUR_W-1:0]  dec;
  logic [1:0]        sel;
  logic              idle_found;

  // full is derived from the registered count, so a pop cannot open a slot in the same cycle
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign in_flush   = (state_q == ST_FLUSH);
  assign note_ready = !full && !in_flush;
  assign wr_en      = note_valid && note_ready && !flush;
  assign rd_en      = !empty && play && !flush && !in_flush;
  assign head_note  = fifo_note_q[rd_ptr_q];
  assign head_dur   = fifo_dur_q[rd_ptr_q];
  assign load_en    = rd_en && (head_dur != '0);
  assign count_en   = play && beat && !in_flush;
  assign dec        = fast_mode ? DUR_W'(2) : DUR_W'(1);

  // Controller next state: flush overrides, FLUSH always lasts one cycle
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (!play) state_d = ST_PAUSE;
        ST_PAUSE: if (play)  state_d = ST_RUN;
        default:  state_d = play ? ST_RUN : ST_PAUSE;
      endcase
    end
  end

  // Voice choice: lowest idle voice, else the one closest to finishing (lowest index on ties)
  always_comb begin
    sel        = 2'd0;
    idle_found = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (remaining_q[i] == '0) begin
        sel        = 2'(i);
        idle_found = 1'b1;
      end
    end
    if (!idle_found) begin
      sel = 2'd0;
      for (int i = 1; i < 3; i++) begin
        if (remaining_q[i] < remaining_q[sel]) sel = 2'(i);
      end
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Voice counters and registered load outputs; a freshly loaded voice skips this beat
  always_comb begin
    load_d  = '0;
    steal_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      remaining_d[i] = remaining_q[i];
      note_d[i]      = '0;
      dur_d[i]       = '0;
      if (flush) begin
        remaining_d[i] = '0;
      end else if (load_en && (sel == 2'(i))) begin
        remaining_d[i] = head_dur;
        note_d[i]      = head_note;
        dur_d[i]       = head_dur;
        load_d[i]      = 1'b1;
      end else if (count_en) begin
        remaining_d[i] = (remaining_q[i] > dec) ? (remaining_q[i] - dec) : '0;
      end
    end
    steal_d = load_en && !idle_found;
  end

  // FIFO storage needs no reset: occupancy alone decides which entries are valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_note_q[wr_ptr_q] <= note_in;
      fifo_dur_q[wr_ptr_q]  <= dur_in;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      load_q   <= '0;
      steal_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        remaining_q[i] <= '0;
        note_q[i]      <= '0;
        dur_q[i]       <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      load_q   <= load_d;
      steal_q  <= steal_d;
      for (int i = 0; i < 3; i++) begin
        remaining_q[i] <= remaining_d[i];
        note_q[i]      <= note_d[i];
        dur_q[i]       <= dur_d[i];
      end
    end
  end

  assign note0      = note_q[0];
  assign duration0  = dur_q[0];
  assign load_note0 = load_q[0];
  assign note1      = note_q[1];
  assign duration1  = dur_q[1];
  assign load_note1 = load_q[1];
  assign note2      = note_q[2];
  assign duration2  = dur_q[2];
  assign load_note2 = load_q[2];
  assign steal      = steal_q;
  assign fifo_count = count_q;
  assign voice_busy = {remaining_q[2] != '0, remaining_q[1] != '0, remaining_q[0] != '0};

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - directed self-checking bench for voice_scheduler
module tb_voice_scheduler;

  logic       clk = 1'b0;
  logic       reset, flush, play, beat, fast_mode, note_valid;
  logic [5:0] note_in, dur_in;
  logic       note_ready;
  logic [5:0] note0, duration0, note1, duration1, note2, duration2;
  logic       load_note0, load_note1, load_note2;
  logic [2:0] voice_busy;
  logic       steal;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  voice_scheduler #(.FIFO_DEPTH(4), .NOTE_W(6), .DUR_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .play(play), .beat(beat),
    .fast_mode(fast_mode), .note_valid(note_valid), .note_in(note_in),
    .dur_in(dur_in), .note_ready(note_ready),
    .note0(note0), .duration0(duration0), .load_note0(load_note0),
    .note1(note1), .duration1(duration1), .load_note1(load_note1),
    .note2(note2), .duration2(duration2), .load_note2(load_note2),
    .voice_busy(voice_busy), .steal(steal), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loads(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, load_note2, load_note1, load_note0}, {29'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; play = 1'b1; beat = 1'b0; fast_mode = 1'b0;
    note_valid = 1'b0; note_in = '0; dur_in = '0;
    #2;
    chk("rst_busy",  voice_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_steal", steal, 0);
    loads("rst_loads", 3'b000);
    chk("rst_note0", note0, 0);
    tick(); tick();
    reset = 1'b1;
    chk("rst_ready", note_ready, 1);

    // single request, then four beats
    note_valid = 1'b1; note_in = 6'd10; dur_in = 6'd4;
    tick();
    note_valid = 1'b0;
    chk("t1_count", fifo_count, 1);
    loads("t1_noload_yet", 3'b000);
    tick();
    loads("t1_load", 3'b001);
    chk("t1_note0", note0, 10);
    chk("t1_dur0", duration0, 4);
    chk("t1_busy", voice_busy, 3'b001);
    tick();
    loads("t1_pulse_end", 3'b000);
    chk("t1_note0_zero", note0, 0);
    beat = 1'b1;
    tick(); tick(); tick();
    chk("t1_busy_3beats", voice_busy, 3'b001);
    tick();
    beat = 1'b0;
    chk("t1_busy_4beats", voice_busy, 3'b000);

    // three back-to-back requests, fourth steals voice 2
    note_valid = 1'b1; note_in = 6'd1; dur_in = 6'd8; tick();
    note_in = 6'd2; dur_in = 6'd6; tick();
    loads("t2_load0", 3'b001);
    chk("t2_note0", note0, 1);
    note_in = 6'd3; dur_in = 6'd5; tick();
    loads("t2_load1", 3'b010);
    chk("t2_note1", note1, 2);
    note_in = 6'd20; dur_in = 6'd3; tick();
    note_valid = 1'b0;
    loads("t2_load2", 3'b100);
    chk("t2_note2", note2, 3);
    chk("t2_nosteal", steal, 0);
    tick();
    loads("t2_steal_load", 3'b100);
    chk("t2_steal", steal, 1);
    chk("t2_steal_note", note2, 20);
    chk("t2_steal_dur", duration2, 3);
    tick();
    chk("t2_steal_end", steal, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_flush_busy", voice_busy, 0);
    chk("t2_flush_ready", note_ready, 0);
    tick();
    chk("t2_ready_back", note_ready, 1);

    // paused FIFO fill to full, then drain
    play = 1'b0; note_valid = 1'b1; dur_in = 6'd2;
    for (int i = 0; i < 5; i++) begin
      note_in = 6'(30 + i);
      chk($sformatf("t3_ready%0d", i), note_ready, (i < 4) ? 1 : 0);
      tick();
    end
    note_valid = 1'b0;
    chk("t3_count_full", fifo_count, 4);
    loads("t3_noloads", 3'b000);
    play = 1'b1;
    tick();
    loads("t3_d0", 3'b001); chk("t3_d0_note", note0, 30); chk("t3_d0_cnt", fifo_count, 3);
    tick();
    loads("t3_d1", 3'b010); chk("t3_d1_note", note1, 31); chk("t3_d1_cnt", fifo_count, 2);
    tick();
    loads("t3_d2", 3'b100); chk("t3_d2_note", note2, 32); chk("t3_d2_cnt", fifo_count, 1);
    tick();
    loads("t3_d3", 3'b001); chk("t3_d3_note", note0, 33);
    chk("t3_d3_steal_tie", steal, 1); chk("t3_d3_cnt", fifo_count, 0);
    flush = 1'b1; tick(); flush = 1'b0; tick();

    // fast mode: 3 -> 1 -> 0
    fast_mode = 1'b1;
    note_valid = 1'b1; note_in = 6'd5; dur_in = 6'd3; tick();
    note_valid = 1'b0; tick();
    chk("t4_busy_load", voice_busy, 3'b001);
    beat = 1'b1; tick();
    chk("t4_busy_1", voice_busy, 3'b001);
    tick();
    chk("t4_busy_0", voice_busy, 3'b000);
    beat = 1'b0; tick();
    chk("t4_no_underflow", voice_busy, 3'b000);
    fast_mode = 1'b0;

    // zero-duration entry is discarded
    note_valid = 1'b1; note_in = 6'd11; dur_in = 6'd0; tick();
    note_valid = 1'b0; tick();
    loads("t5_zero_noload", 3'b000);
    chk("t5_zero_cnt", fifo_count, 0);
    chk("t5_zero_busy", voice_busy, 0);

    // beat coincident with dispatch into voice 0 while voice 1 has 2 left
    note_valid = 1'b1; note_in = 6'd7; dur_in = 6'd1; tick();
    note_in = 6'd8; dur_in = 6'd3; tick();
    note_valid = 1'b0; tick();
    beat = 1'b1; tick(); beat = 1'b0;
    chk("t6_setup_busy", voice_busy, 3'b010);
    note_valid = 1'b1; note_in = 6'd9; dur_in = 6'd5; tick();
    note_valid = 1'b0; beat = 1'b1; tick();
    loads("t6_load0", 3'b001);
    chk("t6_dur0", duration0, 5);
    chk("t6_busy_both", voice_busy, 3'b011);
    tick();
    chk("t6_v1_was_1", voice_busy, 3'b001);
    tick(); tick(); tick();
    chk("t6_v0_4beats", voice_busy, 3'b001);
    tick();
    chk("t6_v0_5beats", voice_busy, 3'b000);
    beat = 1'b0;

    // flush with queued entries and all voices busy
    note_valid = 1'b1; dur_in = 6'd10;
    note_in = 6'd1; tick(); note_in = 6'd2; tick(); note_in = 6'd3; tick();
    note_valid = 1'b0; tick();
    play = 1'b0; note_valid = 1'b1; dur_in = 6'd4;
    note_in = 6'd4; tick(); note_in = 6'd5; tick(); note_in = 6'd6; tick();
    chk("t7_queued", fifo_count, 3);
    chk("t7_all_busy", voice_busy, 3'b111);
    flush = 1'b1; note_in = 6'd7; tick();
    flush = 1'b0; note_valid = 1'b0; play = 1'b1;
    chk("t7_cnt", fifo_count, 0);
    chk("t7_busy", voice_busy, 0);
    loads("t7_noload", 3'b000);
    chk("t7_nosteal", steal, 0);
    tick();
    chk("t7_cnt_after", fifo_count, 0);
    loads("t7_noload_after", 3'b000);

    // asynchronous reset during a load pulse
    note_valid = 1'b1; note_in = 6'd12; dur_in = 6'd6; tick();
    note_in = 6'd13; tick();
    note_valid = 1'b0;
    loads("t8_pre_load", 3'b001);
    #2 reset = 1'b0;
    #1;
    loads("t8_async_load", 3'b000);
    chk("t8_async_note0", note0, 0);
    chk("t8_async_busy", voice_busy, 0);
    chk("t8_async_cnt", fifo_count, 0);
    reset = 1'b1;
    tick();
    loads("t8_no_pending", 3'b000);
    chk("t8_ready", note_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
